// File: rtl/vx_fetch_sched_pkg.sv
// Shared constants for the fetch scheduler: reset PC and the RISC-V
// control-transfer opcodes that park a warp until execute resolves them.
package vx_fetch_sched_pkg;

    localparam logic [31:0] START_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JAL    = 2'd2,
        CF_JALR   = 2'd3
    } cf_kind_e;

    function automatic cf_kind_e cf_kind(input logic [31:0] instr);
        cf_kind_e k;
        k = CF_NONE;
        case (instr[6:0])
            OPC_BRANCH: k = CF_BRANCH;
            OPC_JAL:    k = CF_JAL;
            OPC_JALR:   k = CF_JALR;
            default:    k = CF_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/vx_fetch_sched_if.sv
// Fetch-stage bundle: I-cache request/response, fetch/decode outputs and the
// execute feedback (branch resolution, spawn, thread-mask change).
interface vx_fetch_sched_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic                   in_fwd_stall;
    logic                   in_freeze;
    logic                   in_clone_stall;
    logic [31:0]            icache_response_instruction;
    logic                   in_branch_valid;
    logic                   in_branch_taken;
    logic [31:0]            in_branch_dest;
    logic [WW-1:0]          in_branch_warp_num;
    logic                   in_wspawn;
    logic [31:0]            in_wspawn_pc;
    logic                   in_change_mask;
    logic [WW-1:0]          in_tmc_warp;
    logic [NUM_THREADS-1:0] in_thread_mask;

    logic [31:0]            icache_request_pc_address;
    logic [31:0]            out_instruction;
    logic [31:0]            out_curr_PC;
    logic [NUM_THREADS-1:0] out_valid;
    logic [WW-1:0]          out_warp_num;
    logic                   out_all_done;

    // Outputs are combinational and always meaningful; out_valid == 0 marks a
    // bubble. Downstream registers the bundle unless it raises a stall.
    modport master (
        input  in_fwd_stall, in_freeze, in_clone_stall, icache_response_instruction,
        input  in_branch_valid, in_branch_taken, in_branch_dest, in_branch_warp_num,
        input  in_wspawn, in_wspawn_pc, in_change_mask, in_tmc_warp, in_thread_mask,
        output icache_request_pc_address, out_instruction, out_curr_PC,
        output out_valid, out_warp_num, out_all_done
    );

    modport slave (
        output in_fwd_stall, in_freeze, in_clone_stall, icache_response_instruction,
        output in_branch_valid, in_branch_taken, in_branch_dest, in_branch_warp_num,
        output in_wspawn, in_wspawn_pc, in_change_mask, in_tmc_warp, in_thread_mask,
        input  icache_request_pc_address, out_instruction, out_curr_PC,
        input  out_valid, out_warp_num, out_all_done
    );

endinterface

// File: rtl/vx_fetch_sched_warp_scheduler.sv
// Round-robin pick: first eligible warp scanning from rr_ptr upward, wrapping.
// With nothing eligible, sel_o falls back to rr_ptr and found_o is low.
module vx_fetch_sched_warp_scheduler #(
    parameter int NUM_WARPS = 4,
    parameter int WW        = 2
) (
    input  logic [NUM_WARPS-1:0] eligible_i,
    input  logic [WW-1:0]        rr_ptr_i,
    output logic [WW-1:0]        sel_o,
    output logic                 found_o
);

    logic [WW-1:0] idx;

    // NUM_WARPS is a power of two, so the WW-bit sum wraps modulo NUM_WARPS.
    always_comb begin
        sel_o   = rr_ptr_i;
        found_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = rr_ptr_i + WW'(i);
            if (!found_o && eligible_i[idx]) begin
                found_o = 1'b1;
                sel_o   = idx;
            end
        end
    end

endmodule

// File: rtl/vx_fetch_sched.sv
// Per-warp fetch state (PC, active, thread mask, branch block) with a
// round-robin pick feeding the I-cache and the fetch/decode register.
module vx_fetch_sched
    import vx_fetch_sched_pkg::*;
#(
    parameter logic [31:0] START_PC    = START_PC_DEFAULT,
    parameter int          NUM_WARPS   = 4,
    parameter int          NUM_THREADS = 4
) (
    input logic              clk,
    input logic              reset,
    vx_fetch_sched_if.master fs
);

    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    logic [31:0]            pc_q     [NUM_WARPS];
    logic [31:0]            pc_d     [NUM_WARPS];
    logic [NUM_THREADS-1:0] mask_q   [NUM_WARPS];
    logic [NUM_THREADS-1:0] mask_d   [NUM_WARPS];
    logic [NUM_WARPS-1:0]   active_q, active_d;
    logic [NUM_WARPS-1:0]   blocked_q, blocked_d;
    logic [WW-1:0]          rr_q, rr_d;

    logic [NUM_WARPS-1:0]   eligible;
    logic [WW-1:0]          sel;
    logic                   found;
    logic                   stall;
    logic                   fire;

    assign eligible = active_q & ~blocked_q;
    assign stall    = fs.in_fwd_stall | fs.in_freeze | fs.in_clone_stall;
    assign fire     = found & ~stall;

    vx_fetch_sched_warp_scheduler #(
        .NUM_WARPS (NUM_WARPS),
        .WW        (WW)
    ) u_sched (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_q),
        .sel_o      (sel),
        .found_o    (found)
    );

    assign fs.icache_request_pc_address = pc_q[sel];
    assign fs.out_curr_PC               = pc_q[sel];
    assign fs.out_instruction           = fs.icache_response_instruction;
    assign fs.out_valid                 = found ? mask_q[sel] : '0;
    assign fs.out_warp_num              = sel;
    assign fs.out_all_done              = ~|active_q;

    // Later updates override earlier ones: fire, then branch redirect, then
    // spawn, then mask change (which wins on mask/active over spawn).
    always_comb begin
        pc_d      = pc_q;
        mask_d    = mask_q;
        active_d  = active_q;
        blocked_d = blocked_q;
        rr_d      = rr_q;

        if (fire) begin
            pc_d[sel] = pc_q[sel] + 32'd4;
            rr_d      = sel + WW'(1);
            if (cf_kind(fs.icache_response_instruction) != CF_NONE) begin
                blocked_d[sel] = 1'b1;
            end
        end

        // A resolution aimed at an unblocked warp leaves any fresh block alone.
        if (fs.in_branch_valid) begin
            if (blocked_q[fs.in_branch_warp_num]) begin
                blocked_d[fs.in_branch_warp_num] = 1'b0;
            end
            if (fs.in_branch_taken) begin
                pc_d[fs.in_branch_warp_num] = fs.in_branch_dest;
            end
        end

        if (fs.in_wspawn) begin
            for (int w = 1; w < NUM_WARPS; w++) begin
                active_d[w]  = 1'b1;
                pc_d[w]      = fs.in_wspawn_pc;
                mask_d[w]    = NUM_THREADS'(1);
                blocked_d[w] = 1'b0;
            end
        end

        if (fs.in_change_mask) begin
            mask_d[fs.in_tmc_warp]   = fs.in_thread_mask;
            active_d[fs.in_tmc_warp] = |fs.in_thread_mask;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]   <= (w == 0) ? START_PC : 32'h0;
                mask_q[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
            end
            active_q  <= NUM_WARPS'(1);
            blocked_q <= '0;
            rr_q      <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w]   <= pc_d[w];
                mask_q[w] <= mask_d[w];
            end
            active_q  <= active_d;
            blocked_q <= blocked_d;
            rr_q      <= rr_d;
        end
    end

endmodule

// File: doc/vx_fetch_sched.md
Name: vx_fetch_sched

Overview:
Fetch stage directly upstream of the fetch/decode pipeline register. It holds per-warp PC, active flag, thread mask and branch-block flag, and each cycle picks one eligible warp round-robin. It drives the I-cache address and presents instruction/PC/valid/warp_num to the fetch/decode register. It also applies branch resolution, warp spawn and thread-mask changes fed back from execute.

Parameters:
START_PC, 32'h80000000, reset/spawn PC for warp 0
NUM_WARPS, `NW, warp count (power of two, ≥2)
NUM_THREADS, `NT, threads per warp

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_fwd_stall  in  1  decode forwarding stall
in_freeze  in  1  global pipeline freeze
in_clone_stall  in  1  clone stall
icache_response_instruction  in  32  instruction at icache_request_pc_address, same cycle
in_branch_valid  in  1  branch/jump resolution this cycle
in_branch_taken  in  1  resolution redirects PC
in_branch_dest  in  32  redirect target
in_branch_warp_num  in  `NW_M1+1  warp being resolved
in_wspawn  in  1  spawn warps 1..NUM_WARPS-1
in_wspawn_pc  in  32  PC for spawned warps
in_change_mask  in  1  thread-mask change
in_tmc_warp  in  `NW_M1+1  target warp of mask change
in_thread_mask  in  `NT_M1+1  new thread mask
icache_request_pc_address  out  32  PC of selected warp
out_instruction  out  32  fetched instruction
out_curr_PC  out  32  PC of fetched instruction
out_valid  out  `NT_M1+1  thread mask of fetched instruction; 0 = bubble
out_warp_num  out  `NW_M1+1  selected warp
out_all_done  out  1  no warp active

Behaviour:
- Reset (async, any cycle, including mid-branch-block): warp 0 active, PC=START_PC, mask=1 (thread 0 only), not blocked; all other warps inactive, PC=0, mask=0, not blocked; rr pointer=0. Outputs then: icache addr=START_PC, out_valid=1, out_warp_num=0, out_curr_PC=START_PC, out_all_done=0.
- stall = in_fwd_stall | in_freeze | in_clone_stall.
- eligible[w] = active[w] & ~blocked[w].
- Selection (combinational): first eligible warp scanning rr_ptr, rr_ptr+1, … modulo NUM_WARPS. No eligible warp: out_valid=0, out_warp_num=rr_ptr, out_instruction=icache response (don't-care).
- Outputs are combinational from the selection: out_curr_PC = icache_request_pc_address = PC[sel]; out_valid = mask[sel]; out_instruction = icache_request_pc_address response. Zero-latency; registering is done downstream.
- Fire = eligible warp selected & ~stall. On fire:
  - PC[sel] <= PC[sel]+4 (32-bit wrap).
  - rr_ptr <= sel+1 mod NUM_WARPS.
  - If instruction opcode[6:0] ∈ {1100011 branch, 1101111 JAL, 1100111 JALR}, set blocked[sel]=1.
- Stall: no PC, rr_ptr or blocked update. Selection and outputs are held stable, given stable inputs.
- Branch resolution (in_branch_valid): blocked[w]<=0. If taken, PC[w]<=in_branch_dest; otherwise PC is unchanged (it already holds PC+4). Applied even during stall. Resolution for an unblocked warp is ignored for blocked; taken still redirects PC.
- wspawn: warps 1..NUM_WARPS-1 become active, PC=in_wspawn_pc, mask=1, blocked=0. Warp 0 is untouched. Already-active warps are overwritten.
- Mask change: mask[w]<=in_thread_mask; active[w]<=|in_thread_mask. A zero mask retires the warp.
- Simultaneous events:
  - Fire and mask change on the same warp: the fetched instruction carries the old mask; the new mask applies next cycle.
  - Branch and fire cannot target the same warp, because a blocked warp is ineligible.
  - wspawn and a mask change on the same warp: mask change wins on mask/active; wspawn still sets PC.
- out_all_done = ~|active (registered state).

Decomposition:
- VX_define gains: START_PC, opcode constants BRANCH/JAL/JALR.
- Sub-module VX_warp_scheduler: round-robin priority pick. Inputs eligible vector and rr_ptr; outputs sel index and found.

Test Plan:
- Reset, no stall, warp 0 straight-line code: addresses 80000000, 80000004, 80000008 on successive cycles, out_valid=1, out_warp_num=0.
- Fetch 0x00000063 (beq) at 80000010: next cycle out_valid=0. Inject branch warp0 taken dest 80000100: following cycle address 80000100. Repeat not-taken: resumes at 80000014.
- wspawn pc=80000200 while warp 0 running: warps 0,1,2,… are serviced round-robin. Warp 1 first fetch at 80000200, out_valid=1.
- Assert in_freeze 3 cycles mid-run: address/warp held constant. On release, the next PC is +4 with no skip or duplicate.
- Mask change warp0 to 4'b1010: next fetch out_valid=1010. Then mask 0 on all warps: out_all_done=1, out_valid=0.
- Assert reset while warp 0 is blocked and others are active: immediately only warp 0 active, PC=START_PC, unblocked.
